// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute stage and the iterative mult/div unit.
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hold;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, hold, abort,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hold, abort,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU: one shift-and-add or restoring-divide step per cycle,
// sign correction applied to the magnitudes on the final iteration.
module mult_div_unit (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic        sign_a;
    logic        sign_b;
    logic        div_zero;
    logic [5:0]  count;
    logic [31:0] operand;
    logic [63:0] acc;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        signed_op;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_diff;
    logic [63:0] mul_next;
    logic [63:0] div_next;
    logic [63:0] acc_next;
    logic        negate;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign signed_op = ~bus.op[0];
    assign abs_a     = (signed_op && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    assign abs_b     = (signed_op && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

    // acc holds {product high, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : 32'd0)};
        mul_next = {mul_sum, acc[31:1]};
        div_diff = acc[63:31] - {1'b0, operand};
        div_next = div_diff[32] ? {acc[62:0], 1'b0}
                                : {div_diff[31:0], acc[30:0], 1'b1};
        acc_next = op_q[1] ? div_next : mul_next;
    end

    // A zero divisor leaves the dividend in the remainder, so only the quotient needs overriding.
    assign negate   = sign_a ^ sign_b;
    assign prod_fix = negate ? (64'd0 - acc_next) : acc_next;
    assign quot_fix = div_zero ? 32'hFFFF_FFFF
                               : (negate ? (32'd0 - acc_next[31:0]) : acc_next[31:0]);
    assign rem_fix  = sign_a ? (32'd0 - acc_next[63:32]) : acc_next[63:32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_q     <= 2'b00;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            count    <= 6'd0;
            operand  <= 32'd0;
            acc      <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.hold && !bus.abort) begin
                        op_q     <= bus.op;
                        sign_a   <= signed_op & bus.a[31];
                        sign_b   <= signed_op & bus.b[31];
                        div_zero <= bus.op[1] && (bus.b == 32'd0);
                        operand  <= bus.op[1] ? abs_b : abs_a;
                        acc      <= {32'd0, (bus.op[1] ? abs_a : abs_b)};
                        count    <= 6'd0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (!bus.hold) begin
                        acc   <= acc_next;
                        count <= count + 6'd1;
                        if (count == 6'd31) begin
                            state <= DONE;
                            if (op_q[1]) begin
                                hi_q <= rem_fix;
                                lo_q <= quot_fix;
                            end else begin
                                hi_q <= prod_fix[63:32];
                                lo_q <= prod_fix[31:0];
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: products, quotients, divide-by-zero, hold stretching,
// abort and mid-operation reset, all against hand-computed results.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_cycles = 0;

    always #5 clk = ~clk;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        cyc       = 0;
        tick();
        bus.start = 1'b0;
    endtask

    // Returns with cyc at the cycle where done was seen, or at the limit if it never came.
    task automatic waitDone(input int limit);
        busy_cycles = 0;
        while (cyc < limit) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done === 1'b1) break;
            tick();
        end
    endtask

    task automatic watchNoDone(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick();
            if (bus.done !== 1'b0) seen = 1'b1;
        end
        checkOutput(tag, {63'd0, seen}, 64'd0);
    endtask

    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        applyStimulus(op, a, b);
        checkOutput({tag, " hi held in calc"}, {32'd0, bus.hi}, {32'd0, prev_hi});
        checkOutput({tag, " lo held in calc"}, {32'd0, bus.lo}, {32'd0, prev_lo});
        waitDone(60);
        checkOutput({tag, " done cycle"}, 64'(cyc), 64'd33);
        checkOutput({tag, " busy cycles"}, 64'(busy_cycles), 64'd33);
        checkOutput({tag, " hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        checkOutput({tag, " lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
        tick();
        checkOutput({tag, " done one cycle"}, {63'd0, bus.done}, 64'd0);
        checkOutput({tag, " idle after done"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        #2;
        checkOutput("reset busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("reset done", {63'd0, bus.done}, 64'd0);
        checkOutput("reset hi", {32'd0, bus.hi}, 64'd0);
        checkOutput("reset lo", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        runOp("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
              32'hFFFF_FFFE, 32'h0000_0001);
        runOp("mult -3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFE, 32'h0000_0001,
              32'hFFFF_FFFF, 32'hFFFF_FFF1);
        runOp("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divu 7/0", 2'b11, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
              32'h0000_0007, 32'hFFFF_FFFF);
        runOp("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF,
              32'h0000_0000, 32'h8000_0000);

        // DIVU 100/7 with a stray start while busy and five held cycles.
        applyStimulus(2'b11, 32'd100, 32'd7);
        while (cyc < 5) tick();
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd5;
        bus.b     = 32'd1;
        tick();
        bus.start = 1'b0;
        while (cyc < 10) tick();
        bus.hold = 1'b1;
        repeat (5) tick();
        checkOutput("hold busy", {63'd0, bus.busy}, 64'd1);
        bus.hold = 1'b0;
        waitDone(80);
        checkOutput("hold done cycle", 64'(cyc), 64'd38);
        checkOutput("hold lo", {32'd0, bus.lo}, 64'd14);
        checkOutput("hold hi", {32'd0, bus.hi}, 64'd2);
        tick();

        bus.hold  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        checkOutput("start under hold", {63'd0, bus.busy}, 64'd0);

        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checkOutput("start with abort", {63'd0, bus.busy}, 64'd0);

        runOp("multu 6x7", 2'b01, 32'd6, 32'd7, 32'd2, 32'd14, 32'd0, 32'd42);

        // Abort together with hold at cycle 10 of a new multiply.
        applyStimulus(2'b01, 32'd9, 32'd9);
        while (cyc < 10) tick();
        bus.abort = 1'b1;
        bus.hold  = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.hold  = 1'b0;
        checkOutput("abort idle", {63'd0, bus.busy}, 64'd0);
        checkOutput("abort hi kept", {32'd0, bus.hi}, 64'd0);
        checkOutput("abort lo kept", {32'd0, bus.lo}, 64'd42);
        watchNoDone("abort no done", 40);

        // Reset dropped at cycle 10 of a multiply.
        applyStimulus(2'b01, 32'd6, 32'd7);
        while (cyc < 10) tick();
        reset = 1'b0;
        #1;
        checkOutput("midreset busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("midreset hi", {32'd0, bus.hi}, 64'd0);
        checkOutput("midreset lo", {32'd0, bus.lo}, 64'd0);
        tick();
        reset = 1'b1;
        watchNoDone("midreset no done", 40);
        checkOutput("midreset stays idle", {63'd0, bus.busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
